sobel_stream_tx: RTL and testbench
==================================

Name: sobel_stream_tx

Overview:
Transmit-side feeder for the Sobel filter's 128-bit word interface. Accepts a host-side 32-bit RGBA pixel stream with a valid/ready handshake and packs four pixels per 128-bit word. Emits each word with a single-cycle valid pulse, which is the exact form the filter's data input consumes. Tracks line and frame position, zero-pads partial words at end of line, and reports frame boundaries.

Parameters:
IMG_WIDTH, 640, pixels per line (>=1)
IMG_HEIGHT, 480, lines per frame (>=1)
PIX_W, 32, bits per input pixel; fixed, PIX_PER_WORD*PIX_W must equal 128
PIX_PER_WORD, 4, pixels packed per output word

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse; begins a frame, honoured only in IDLE
pix_in  input  32  input pixel
pix_valid  input  1  pix_in is valid
pix_ready  output  1  block accepts pix_in this cycle
data_out  output  128  packed word; lane k = data_out[32k +: 32], lane 0 = earliest pixel
valid_out  output  1  data_out valid, one-cycle pulse per word
sof  output  1  qualifies the first word of a frame (high only with valid_out)
eol  output  1  qualifies the last word of a line (high only with valid_out)
busy  output  1  high in RUN and DONE
frame_done  output  1  one-cycle pulse, coincident with the last word's valid_out

Behaviour:
- Reset (rst low, asynchronous): state IDLE; data_out=0, valid_out=0, pix_ready=0, sof=0, eol=0, busy=0, frame_done=0; col, row, lane counters and assembly buffer cleared. Takes effect immediately, including mid-frame. A partial word is discarded.
- Accept condition: pix_valid && pix_ready.
- States:
  - IDLE: pix_ready=0. start moves to RUN; col, row, lane are cleared and first_word is set.
  - RUN: pix_ready=1 every cycle. There is no backpressure from downstream. Each accept writes pix_in into assembly lane `lane` and increments col.
  - DONE: lasts exactly one cycle. pix_ready=0. Unconditionally returns to IDLE.
- Word emission: a word is emitted on an accept that fills lane PIX_PER_WORD-1 or that carries the last pixel of a line (col==IMG_WIDTH-1).
  - On the next cycle: valid_out=1 and data_out = assembled lanes. Unfilled lanes are 0.
  - Latency is 1 cycle from the accepting edge.
  - The assembly buffer and lane are cleared on the same edge, so a back-to-back accept starts a fresh word with no bubble.
- data_out holds its last value when valid_out=0. valid_out never stays high for two cycles for the same word.
- sof=1 with the first word emitted after start, then first_word clears.
- eol=1 with the word containing col==IMG_WIDTH-1. col wraps to 0 and row increments.
- Last pixel of the frame (row==IMG_HEIGHT-1, col==IMG_WIDTH-1) moves RUN to DONE. In DONE: valid_out=1, eol=1, frame_done=1 together.
- start outside IDLE is ignored with no effect. Pixels offered in IDLE or DONE are not accepted (pix_ready=0).
- Words per line = ceil(IMG_WIDTH/PIX_PER_WORD). Counters are sized with $clog2 of IMG_WIDTH, IMG_HEIGHT and PIX_PER_WORD.
- Single-pixel frame (W=H=1): start, then one accept. The next cycle has valid_out, sof, eol and frame_done all high.

Test Plan:
- W=8, H=2, start, pixels 0x1..0x10 with pix_valid held high -> 4 words, each 1 cycle after its 4th accept.
  - word0 = 0x00000004_00000003_00000002_00000001 with sof=1.
  - eol on words 1 and 3; frame_done with word3; busy low the cycle after.
- W=6, H=1, pixels 1..6 -> word0 {4,3,2,1}; word1 = 0x00000000_00000000_00000006_00000005 with eol=1 and frame_done=1.
- W=8, H=2 with random pix_valid bubbles (~40%) -> words identical to the first test. valid_out pulses only after lane 3 fills; never two cycles wide.
- Reset mid-frame: rst low after 5 accepts -> all outputs 0 asynchronously. After release, pix_ready=0 until start. A new frame yields word0 = {4,3,2,1} with sof=1 and no stale lanes.
- start pulsed during RUN and in the DONE cycle -> ignored; the frame completes normally and the block returns to IDLE.
- W=1, H=1, pix 0xDEADBEEF -> one word 0x..._DEADBEEF with upper lanes 0; valid_out, sof, eol and frame_done all high in the same cycle.

Source files
------------

// File: rtl/sobel_stream_tx_if.sv
// Pixel-in / word-out bundle between a host pixel source and the Sobel TX packer.
// The slave side is the packer; the master side is the host or its bench.
interface sobel_stream_tx_if #(
  parameter int PIX_W  = 32,
  parameter int WORD_W = 128
);
  logic [PIX_W-1:0]  pix_in;
  logic              pix_valid;
  logic              pix_ready;
  logic [WORD_W-1:0] data_out;
  logic              valid_out;
  logic              sof;
  logic              eol;

  modport master (
    output pix_in, pix_valid,
    input  pix_ready, data_out, valid_out, sof, eol
  );

  modport slave (
    input  pix_in, pix_valid,
    output pix_ready, data_out, valid_out, sof, eol
  );
endinterface

// File: rtl/sobel_stream_tx.sv
// Packs a 32-bit pixel stream four-per-word into 128-bit single-cycle pulses for the
// Sobel filter, zero-padding the last word of each line and flagging frame boundaries.
//
// state  | meaning
// IDLE   | waiting for start, pixels refused
// RUN    | accepting pixels every cycle, emitting words
// DONE   | one cycle carrying the final word, then back to IDLE
module sobel_stream_tx #(
  parameter int IMG_WIDTH    = 640,
  parameter int IMG_HEIGHT   = 480,
  parameter int PIX_W        = 32,
  parameter int PIX_PER_WORD = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  sobel_stream_tx_if.slave      bus,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int WORD_W = PIX_W * PIX_PER_WORD;
  localparam int COL_W  = (IMG_WIDTH > 1)    ? $clog2(IMG_WIDTH)    : 1;
  localparam int ROW_W  = (IMG_HEIGHT > 1)   ? $clog2(IMG_HEIGHT)   : 1;
  localparam int LANE_W = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;

  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(PIX_PER_WORD - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              state_q;
  logic [COL_W-1:0]    col_q;
  logic [ROW_W-1:0]    row_q;
  logic [LANE_W-1:0]   lane_q;
  logic [WORD_W-1:0]   buf_q;
  logic                first_word_q;
  logic [WORD_W-1:0]   data_q;
  logic                valid_q;
  logic                sof_q;
  logic                eol_q;
  logic                done_q;
  logic                ready_q;
  logic                busy_q;

  logic                accept;
  logic                line_end;
  logic                frame_end;
  logic                word_full;
  logic [WORD_W-1:0]   word_d;

  assign accept    = bus.pix_valid && ready_q;
  assign line_end  = (col_q == COL_LAST);
  assign frame_end = line_end && (row_q == ROW_LAST);
  assign word_full = (lane_q == LANE_LAST);

  // Current pixel merged into its lane; lanes above it are still zero from the last clear.
  always_comb begin
    word_d = buf_q;
    word_d[int'(lane_q)*PIX_W +: PIX_W] = bus.pix_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      lane_q       <= '0;
      buf_q        <= '0;
      first_word_q <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      sof_q        <= 1'b0;
      eol_q        <= 1'b0;
      done_q       <= 1'b0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q      <= S_RUN;
            col_q        <= '0;
            row_q        <= '0;
            lane_q       <= '0;
            buf_q        <= '0;
            first_word_q <= 1'b1;
            ready_q      <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        S_RUN: begin
          if (accept) begin
            if (word_full || line_end) begin
              data_q       <= word_d;
              valid_q      <= 1'b1;
              sof_q        <= first_word_q;
              eol_q        <= line_end;
              first_word_q <= 1'b0;
              buf_q        <= '0;
              lane_q       <= '0;
            end else begin
              buf_q  <= word_d;
              lane_q <= lane_q + 1'b1;
            end
            if (line_end) begin
              col_q <= '0;
              if (frame_end) begin
                state_q <= S_DONE;
                ready_q <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                row_q <= row_q + 1'b1;
              end
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pix_ready = ready_q;
  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.sof       = sof_q;
  assign bus.eol       = eol_q;
  assign busy          = busy_q;
  assign frame_done    = done_q;

endmodule

// File: tb/tb_sobel_stream_tx.sv
// Directed bench for sobel_stream_tx: three instances (8x2, 6x1, 1x1) driven from
// per-cycle vector tables plus hand-written bubble, reset and start-ignore sequences.
module tb_sobel_stream_tx;

  typedef struct {
    logic         start;
    logic         pv;
    logic [31:0]  pix;
    logic         ready;
    logic         vo;
    logic         sof;
    logic         eol;
    logic         fd;
    logic         busy;
    logic [127:0] data;
  } vec_t;

  typedef struct {
    logic [127:0] data;
    logic         sof;
    logic         eol;
    logic         fd;
  } word_t;

  localparam logic [127:0] W0  = 128'h00000004_00000003_00000002_00000001;
  localparam logic [127:0] W1  = 128'h00000008_00000007_00000006_00000005;
  localparam logic [127:0] W2  = 128'h0000000C_0000000B_0000000A_00000009;
  localparam logic [127:0] W3  = 128'h00000010_0000000F_0000000E_0000000D;
  localparam logic [127:0] W6B = 128'h00000000_00000000_00000006_00000005;
  localparam logic [127:0] WC  = 128'h00000000_00000000_00000000_DEADBEEF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic busy_a, busy_b, busy_c;
  logic fd_a, fd_b, fd_c;

  int n_cmp = 0;
  int n_bad = 0;

  vec_t  t_a[$], t_b[$], t_c[$], vq[$];
  word_t cap_a[$];
  word_t exp8[4];
  logic  prev_vo = 1'b0;

  sobel_stream_tx_if if_a ();
  sobel_stream_tx_if if_b ();
  sobel_stream_tx_if if_c ();

  sobel_stream_tx #(.IMG_WIDTH(8), .IMG_HEIGHT(2)) dut_a (
    .clk(clk), .rst(rst_n), .start(start_a), .bus(if_a), .busy(busy_a), .frame_done(fd_a));
  sobel_stream_tx #(.IMG_WIDTH(6), .IMG_HEIGHT(1)) dut_b (
    .clk(clk), .rst(rst_n), .start(start_b), .bus(if_b), .busy(busy_b), .frame_done(fd_b));
  sobel_stream_tx #(.IMG_WIDTH(1), .IMG_HEIGHT(1)) dut_c (
    .clk(clk), .rst(rst_n), .start(start_c), .bus(if_c), .busy(busy_c), .frame_done(fd_c));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic pv, input logic [31:0] pix,
                              input logic rdy, input logic vo, input logic sof,
                              input logic eol, input logic fd, input logic bsy,
                              input logic [127:0] data);
    vec_t v;
    v.start = st; v.pv = pv; v.pix = pix; v.ready = rdy; v.vo = vo;
    v.sof = sof; v.eol = eol; v.fd = fd; v.busy = bsy; v.data = data;
    return v;
  endfunction

  // Word-level monitor on instance A: capture each word and flag wide pulses or stray qualifiers.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_vo = 1'b0;
    end else begin
      if (if_a.valid_out) begin
        n_cmp++;
        if (prev_vo) begin
          n_bad++;
          $display("FAIL pulse_width: valid_out high two cycles, got 1 want 0 on second cycle");
        end
        cap_a.push_back('{if_a.data_out, if_a.sof, if_a.eol, fd_a});
      end else if (if_a.sof || if_a.eol || fd_a) begin
        n_cmp++;
        n_bad++;
        $display("FAIL qualifier: sof/eol/fd=%b%b%b with valid_out 0, want 000",
                 if_a.sof, if_a.eol, fd_a);
      end
      prev_vo = if_a.valid_out;
    end
  end

  task automatic drive_idle();
    start_a = 0; start_b = 0; start_c = 0;
    if_a.pix_valid = 0; if_b.pix_valid = 0; if_c.pix_valid = 0;
    if_a.pix_in = '0; if_b.pix_in = '0; if_c.pix_in = '0;
  endtask

  task automatic run_row(input int sel, input vec_t v, input string tag);
    logic rdy, vo, sof, eol, fd, bsy;
    logic [127:0] dat;
    @(negedge clk);
    drive_idle();
    case (sel)
      0: begin start_a = v.start; if_a.pix_valid = v.pv; if_a.pix_in = v.pix; end
      1: begin start_b = v.start; if_b.pix_valid = v.pv; if_b.pix_in = v.pix; end
      default: begin start_c = v.start; if_c.pix_valid = v.pv; if_c.pix_in = v.pix; end
    endcase
    @(posedge clk);
    #1;
    case (sel)
      0: begin rdy = if_a.pix_ready; vo = if_a.valid_out; sof = if_a.sof; eol = if_a.eol;
               fd = fd_a; bsy = busy_a; dat = if_a.data_out; end
      1: begin rdy = if_b.pix_ready; vo = if_b.valid_out; sof = if_b.sof; eol = if_b.eol;
               fd = fd_b; bsy = busy_b; dat = if_b.data_out; end
      default: begin rdy = if_c.pix_ready; vo = if_c.valid_out; sof = if_c.sof; eol = if_c.eol;
               fd = fd_c; bsy = busy_c; dat = if_c.data_out; end
    endcase
    chk({tag, " pix_ready"},  rdy, v.ready);
    chk({tag, " valid_out"},  vo,  v.vo);
    chk({tag, " sof"},        sof, v.sof);
    chk({tag, " eol"},        eol, v.eol);
    chk({tag, " frame_done"}, fd,  v.fd);
    chk({tag, " busy"},       bsy, v.busy);
    if (v.vo) chk({tag, " data_out"}, dat, v.data);
  endtask

  task automatic run_table(input int sel, input string tag);
    foreach (vq[i]) run_row(sel, vq[i], $sformatf("%s[%0d]", tag, i));
    @(negedge clk);
    drive_idle();
  endtask

  task automatic check_words_a(input string tag);
    chk({tag, " word_count"}, 128'(cap_a.size()), 128'd4);
    for (int i = 0; i < 4 && i < cap_a.size(); i++) begin
      chk($sformatf("%s w%0d data", tag, i), cap_a[i].data, exp8[i].data);
      chk($sformatf("%s w%0d sof", tag, i),  cap_a[i].sof,  exp8[i].sof);
      chk($sformatf("%s w%0d eol", tag, i),  cap_a[i].eol,  exp8[i].eol);
      chk($sformatf("%s w%0d fd", tag, i),   cap_a[i].fd,   exp8[i].fd);
    end
  endtask

  initial begin
    logic [127:0] wa[4];
    int p, cyc;
    logic rdy, acc;

    wa[0] = W0; wa[1] = W1; wa[2] = W2; wa[3] = W3;
    exp8[0] = '{W0, 1'b1, 1'b0, 1'b0};
    exp8[1] = '{W1, 1'b0, 1'b1, 1'b0};
    exp8[2] = '{W2, 1'b0, 1'b0, 1'b0};
    exp8[3] = '{W3, 1'b0, 1'b1, 1'b1};

    // 8x2 frame, pix_valid held: words after accepts 4,8,12,16; eol on 8 and 16.
    t_a.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 1, '0));
    for (int k = 1; k <= 16; k++)
      t_a.push_back(mk(0, 1, 32'(k), k != 16, (k % 4) == 0, k == 4, k == 8 || k == 16,
                       k == 16, 1, (k % 4) == 0 ? wa[k/4-1] : '0));
    t_a.push_back(mk(0, 1, 32'h77, 0, 0, 0, 0, 0, 0, '0));
    t_a.push_back(mk(0, 1, 32'h99, 0, 0, 0, 0, 0, 0, '0));

    t_b.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 1, '0));
    t_b.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 1, '0));
    t_b.push_back(mk(0, 1, 2, 1, 0, 0, 0, 0, 1, '0));
    t_b.push_back(mk(0, 1, 3, 1, 0, 0, 0, 0, 1, '0));
    t_b.push_back(mk(0, 1, 4, 1, 1, 1, 0, 0, 1, W0));
    t_b.push_back(mk(0, 1, 5, 1, 0, 0, 0, 0, 1, '0));
    t_b.push_back(mk(0, 1, 6, 0, 1, 0, 1, 1, 1, W6B));
    t_b.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, '0));

    t_c.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 1, '0));
    t_c.push_back(mk(0, 1, 32'hDEADBEEF, 0, 1, 1, 1, 1, 1, WC));
    t_c.push_back(mk(0, 1, 32'h12345678, 0, 0, 0, 0, 0, 0, '0));

    drive_idle();
    #12;
    chk("rst A data_out",  if_a.data_out,  '0);
    chk("rst A valid_out", if_a.valid_out, 1'b0);
    chk("rst A pix_ready", if_a.pix_ready, 1'b0);
    chk("rst A busy",      busy_a,         1'b0);
    chk("rst B pix_ready", if_b.pix_ready, 1'b0);
    chk("rst C busy",      busy_c,         1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    vq = t_a;
    run_table(0, "a_held");

    // Random pix_valid bubbles; a small model predicts which accepts close a word.
    cap_a.delete();
    @(negedge clk);
    start_a = 1;
    @(posedge clk);
    p = 1; cyc = 0;
    while (p <= 16 && cyc < 300) begin
      @(negedge clk);
      start_a = 0;
      if_a.pix_valid = ($urandom_range(0, 99) >= 40);
      if_a.pix_in = 32'(p);
      rdy = if_a.pix_ready;
      @(posedge clk);
      #1;
      acc = if_a.pix_valid && rdy;
      chk($sformatf("bubble p%0d valid_out", p), if_a.valid_out, acc && (p % 4 == 0));
      if (acc) p++;
      cyc++;
    end
    if (p <= 16) begin
      n_cmp++; n_bad++;
      $display("FAIL bubble_timeout: accepted %0d pixels, want 16", p - 1);
    end
    @(negedge clk);
    drive_idle();
    repeat (3) @(negedge clk);
    check_words_a("bubble");

    // start pulsed mid-RUN and in the DONE cycle must change nothing.
    vq = t_a;
    vq[6].start = 1'b1;
    vq[17].start = 1'b1;
    run_table(0, "a_start_ign");

    // Reset after 5 accepts: outputs clear immediately, then a clean frame.
    for (int i = 0; i < 6; i++) run_row(0, t_a[i], $sformatf("a_pre_rst[%0d]", i));
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst data_out",   if_a.data_out,  '0);
    chk("midrst valid_out",  if_a.valid_out, 1'b0);
    chk("midrst pix_ready",  if_a.pix_ready, 1'b0);
    chk("midrst busy",       busy_a,         1'b0);
    chk("midrst sof_eol_fd", {if_a.sof, if_a.eol, fd_a}, 3'b000);
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if_a.pix_valid = 1;
      @(posedge clk);
      #1;
      chk($sformatf("post_rst%0d pix_ready", i), if_a.pix_ready, 1'b0);
      chk($sformatf("post_rst%0d valid_out", i), if_a.valid_out, 1'b0);
    end
    vq = t_a;
    run_table(0, "a_after_rst");

    vq = t_b;
    run_table(1, "b_6x1");
    vq = t_c;
    run_table(2, "c_1x1");

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
